// File: rtl/data_mem_bridge_pkg.sv
// Shared encodings for the data-memory bridge: access sizes, FSM states and
// the default MMIO register address.
package data_mem_bridge_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [31:0] MMIO_BASE_DEF = 32'h0000_2000;

   typedef enum logic {
      ST_IDLE,
      ST_MERGE
   } state_e;

   // The reserved size code behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? SZ_WORD : size;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/data_mem_bridge_if.sv
// Core-side request bus plus SRAM-side port of the data-memory bridge.
// slave: the bridge; master: the core/SRAM environment driving it.
interface data_mem_bridge_if #(
   parameter int unsigned ADDR_W = 10
);
   logic [31:0]       req_addr_i;
   logic [31:0]       req_wdata_i;
   logic              req_we_i;
   logic              req_re_i;
   logic [3:0]        req_mask_i;
   logic [31:0]       rdata_o;
   logic              stall_o;
   logic              misalign_o;
   logic [ADDR_W-1:0] sram_addr_o;
   logic              sram_re_o;
   logic              sram_we_o;
   logic [31:0]       sram_wdata_o;
   logic [31:0]       sram_rdata_i;
   logic [31:0]       mmio_o;

   modport slave (
      input  req_addr_i, req_wdata_i, req_we_i, req_re_i, req_mask_i, sram_rdata_i,
      output rdata_o, stall_o, misalign_o, sram_addr_o, sram_re_o, sram_we_o,
             sram_wdata_o, mmio_o
   );

   modport master (
      output req_addr_i, req_wdata_i, req_we_i, req_re_i, req_mask_i, sram_rdata_i,
      input  rdata_o, stall_o, misalign_o, sram_addr_o, sram_re_o, sram_we_o,
             sram_wdata_o, mmio_o
   );
endinterface

// File: rtl/data_mem_bridge_lane_align.sv
// Byte-lane helper: load extraction with sign/zero extension (i_store=0) or
// sub-word store merge into an existing word (i_store=1).
module lane_align
   import data_mem_bridge_pkg::*;
(
   input  logic        i_store,
   input  logic [31:0] i_word,
   input  logic [15:0] i_wdata,
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic        i_unsigned,
   output logic [31:0] o_word
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_mask;
   logic [31:0] w_ins;

   always_comb begin
      case (i_off)
         2'd0: w_byte = i_word[7:0];
         2'd1: w_byte = i_word[15:8];
         2'd2: w_byte = i_word[23:16];
         2'd3: w_byte = i_word[31:24];
      endcase
      w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

      case (i_size)
         SZ_BYTE: w_load = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
         SZ_HALF: w_load = {{16{w_half[15] & ~i_unsigned}}, w_half};
         default: w_load = i_word;
      endcase

      // Only sub-word stores are merged; anything that is not a byte is a half.
      if (i_size == SZ_BYTE) begin
         w_mask = 32'h0000_00FF << {i_off, 3'b000};
         w_ins  = {4{i_wdata[7:0]}};
      end else begin
         w_mask = 32'h0000_FFFF << {i_off[1], 4'b0000};
         w_ins  = {2{i_wdata}};
      end

      o_word = i_store ? ((i_word & ~w_mask) | (w_ins & w_mask)) : w_load;
   end
endmodule

// File: rtl/data_mem_bridge.sv
// RV32I data-memory bridge to a word SRAM: lane handling, sub-word RMW stores,
// misalignment flag. Optional MMIO output register via DATA_MEM_BRIDGE_MMIO_EN.
module data_mem_bridge
   import data_mem_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   data_mem_bridge_if.slave  bus
);
   state_e            r_state, w_next;
   logic              r_ld_valid, r_ld_uns, r_misalign;
   logic [1:0]        r_ld_off, r_ld_size, r_st_off, r_st_size;
   logic [ADDR_W-1:0] r_st_addr;
   logic [15:0]       r_st_data;

   logic [1:0]        w_size, w_off;
   logic              w_req, w_hit, w_bad, w_accept;
   logic              w_ld_cap, w_st_cap, w_re, w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [31:0]       w_wdata, w_ld_word, w_ld_data, w_merged;
   logic              w_unused_mask;

   assign w_size        = norm_size(bus.req_mask_i[1:0]);
   assign w_off         = bus.req_addr_i[1:0];
   assign w_req         = bus.req_we_i | bus.req_re_i;
   assign w_unused_mask = bus.req_mask_i[3];

`ifdef DATA_MEM_BRIDGE_MMIO_EN
   logic [31:0] r_mmio;
   logic        r_ld_mmio;

   assign w_hit     = (bus.req_addr_i == MMIO_BASE);
   assign w_bad     = misaligned(w_size, w_off) | (w_hit & bus.req_we_i & (w_size != SZ_WORD));
   assign w_ld_word = r_ld_mmio ? r_mmio : bus.sram_rdata_i;
   assign bus.mmio_o = r_mmio;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_mmio    <= '0;
         r_ld_mmio <= 1'b0;
      end else begin
         if (w_accept && bus.req_we_i && w_hit) r_mmio <= bus.req_wdata_i;
         if (w_ld_cap) r_ld_mmio <= w_hit;
      end
   end
`else
   logic w_unused_addr;

   assign w_hit         = 1'b0;
   assign w_bad         = misaligned(w_size, w_off);
   assign w_ld_word     = bus.sram_rdata_i;
   assign bus.mmio_o    = '0;
   assign w_unused_addr = ^{bus.req_addr_i[31:ADDR_W+2], MMIO_BASE};
`endif

   assign w_accept = (r_state == ST_IDLE) & w_req & ~w_bad;

   always_comb begin
      w_next   = r_state;
      w_re     = 1'b0;
      w_we     = 1'b0;
      w_addr   = bus.req_addr_i[ADDR_W+1:2];
      w_wdata  = bus.req_wdata_i;
      w_ld_cap = 1'b0;
      w_st_cap = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (bus.req_we_i) begin
                  if (!w_hit) begin
                     if (w_size == SZ_WORD) begin
                        w_we = 1'b1;
                     end else begin
                        w_re     = 1'b1;
                        w_st_cap = 1'b1;
                        w_next   = ST_MERGE;
                     end
                  end
               end else begin
                  w_ld_cap = 1'b1;
                  w_re     = ~w_hit;
               end
            end
         end
         ST_MERGE: begin
            w_addr  = r_st_addr;
            w_wdata = w_merged;
            w_we    = 1'b1;
            w_next  = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state    <= ST_IDLE;
         r_ld_valid <= 1'b0;
         r_ld_off   <= '0;
         r_ld_size  <= '0;
         r_ld_uns   <= 1'b0;
         r_misalign <= 1'b0;
         r_st_addr  <= '0;
         r_st_data  <= '0;
         r_st_size  <= '0;
         r_st_off   <= '0;
      end else begin
         r_state    <= w_next;
         r_ld_valid <= w_ld_cap;
         r_misalign <= (r_state == ST_IDLE) & w_req & w_bad;
         if (w_ld_cap) begin
            r_ld_off  <= w_off;
            r_ld_size <= w_size;
            r_ld_uns  <= bus.req_mask_i[2];
         end
         if (w_st_cap) begin
            r_st_addr <= bus.req_addr_i[ADDR_W+1:2];
            r_st_data <= bus.req_wdata_i[15:0];
            r_st_size <= w_size;
            r_st_off  <= w_off;
         end
      end
   end

   lane_align u_load (
      .i_store    (1'b0),
      .i_word     (w_ld_word),
      .i_wdata    ('0),
      .i_size     (r_ld_size),
      .i_off      (r_ld_off),
      .i_unsigned (r_ld_uns),
      .o_word     (w_ld_data)
   );

   lane_align u_merge (
      .i_store    (1'b1),
      .i_word     (bus.sram_rdata_i),
      .i_wdata    (r_st_data),
      .i_size     (r_st_size),
      .i_off      (r_st_off),
      .i_unsigned (1'b0),
      .o_word     (w_merged)
   );

   // Enables are masked by reset so a write pending in MERGE never reaches the SRAM.
   assign bus.sram_re_o    = w_re & ~reset_i;
   assign bus.sram_we_o    = w_we & ~reset_i;
   assign bus.sram_addr_o  = w_addr;
   assign bus.sram_wdata_o = w_wdata;
   assign bus.stall_o      = (r_state == ST_MERGE);
   assign bus.misalign_o   = r_misalign;
   assign bus.rdata_o      = r_ld_valid ? w_ld_data : '0;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: directed scenarios plus random
// traffic against a word-array reference model and a behavioural SRAM.
module tb_data_mem_bridge;
   localparam int unsigned AW = 10;
`ifdef DATA_MEM_BRIDGE_MMIO_EN
   localparam bit MMIO = 1'b1;
`else
   localparam bit MMIO = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_i = 1'b1;
   always #5 clk = ~clk;

   data_mem_bridge_if #(.ADDR_W(AW)) bus ();

   data_mem_bridge #(.ADDR_W(AW)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   // Behavioural SRAM: one-cycle read latency, full-word writes.
   logic [31:0] sram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.sram_we_o) sram[bus.sram_addr_o] <= bus.sram_wdata_o;
      if (bus.sram_re_o) bus.sram_rdata_i <= sram[bus.sram_addr_o];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [31:0] model_mem [0:(1<<AW)-1];
   logic [31:0] m_mmio = '0;
   bit          m_merge = 1'b0;
   logic [9:0]  m_idx = '0;
   logic [31:0] m_old = '0;
   logic [31:0] nxt_rdata = '0;
   bit          nxt_mis = 1'b0;

   logic [31:0] exp_rdata = '0, exp_mmio = '0, exp_wd = '0;
   logic [9:0]  exp_addr = '0;
   bit          exp_stall = 1'b0, exp_mis = 1'b0, exp_re = 1'b0, exp_we = 1'b0;
   bit          chk_en = 1'b0;

   function automatic logic [31:0] ref_load(input logic [31:0] w, input int sz,
                                            input logic [1:0] off, input logic uns);
      logic [31:0] v;
      if (sz == 0) begin
         v = (w >> (8 * off)) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
         v = (w >> (16 * off[1])) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] d,
                                             input int sz, input logic [1:0] off);
      logic [31:0] m;
      int          sh;
      sh = (sz == 0) ? 8 * off : 16 * off[1];
      m  = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
      return (w & ~m) | ((d << sh) & m);
   endfunction

   // One cycle: publish expectations for outputs caused by the previous
   // request, then present a new request and predict its effects.
   task automatic step(input logic rst, input logic we, input logic re, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] wd);
      int         sz;
      logic [1:0] off;
      logic [9:0] idx;
      bit         hit, mis;
      @(posedge clk);
      #2;
      exp_rdata = nxt_rdata;
      exp_mis   = nxt_mis;
      exp_mmio  = m_mmio;
      exp_stall = m_merge;
      reset_i   = rst;
      bus.req_we_i = we;  bus.req_re_i = re;  bus.req_addr_i = addr;
      bus.req_mask_i = mask;  bus.req_wdata_i = wd;
      exp_re = 0; exp_we = 0; exp_addr = '0; exp_wd = '0; nxt_rdata = '0; nxt_mis = 0;
      sz  = (mask[1:0] == 2'b11) ? 2 : int'(mask[1:0]);
      off = addr[1:0];
      idx = addr[11:2];
      hit = MMIO && (addr == 32'h0000_2000);
      if (rst) begin
         if (m_merge) model_mem[m_idx] = m_old;
         m_merge = 0; m_mmio = '0;
         exp_mmio = '0; exp_stall = 0; exp_rdata = '0; exp_mis = 0;
      end else if (m_merge) begin
         exp_we = 1; exp_addr = m_idx; exp_wd = model_mem[m_idx];
         m_merge = 0;
      end else if (we || re) begin
         mis = (sz == 1 && off[0]) || (sz == 2 && off != 0) || (hit && we && sz != 2);
         if (mis) begin
            nxt_mis = 1;
         end else if (we) begin
            if (hit) begin
               m_mmio = wd;
            end else if (sz == 2) begin
               exp_we = 1; exp_addr = idx; exp_wd = wd; model_mem[idx] = wd;
            end else begin
               exp_re = 1; exp_addr = idx;
               m_idx = idx; m_old = model_mem[idx];
               model_mem[idx] = ref_merge(model_mem[idx], wd, sz, off);
               m_merge = 1;
            end
         end else begin
            if (!hit) begin exp_re = 1; exp_addr = idx; end
            nxt_rdata = ref_load(hit ? m_mmio : model_mem[idx], sz, off, mask[2]);
         end
      end
   endtask

   task automatic nop(); step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0); endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall_o", 32'(bus.stall_o), 32'(exp_stall));
         chk("rdata_o", bus.rdata_o, exp_rdata);
         chk("misalign_o", 32'(bus.misalign_o), 32'(exp_mis));
         chk("sram_re_o", 32'(bus.sram_re_o), 32'(exp_re));
         chk("sram_we_o", 32'(bus.sram_we_o), 32'(exp_we));
         chk("mmio_o", bus.mmio_o, exp_mmio);
         if (exp_re || exp_we) chk("sram_addr_o", 32'(bus.sram_addr_o), 32'(exp_addr));
         if (exp_we) chk("sram_wdata_o", bus.sram_wdata_o, exp_wd);
      end
   end

   initial begin
      logic [31:0] saved;
      int          mism;
      for (int i = 0; i < (1 << AW); i++) begin sram[i] = '0; model_mem[i] = '0; end
      bus.sram_rdata_i = '0;
      bus.req_we_i = 1'b1; bus.req_re_i = 1'b1; bus.req_addr_i = 32'h10;
      bus.req_mask_i = 4'h2; bus.req_wdata_i = 32'hFFFF_FFFF;
      step(1'b1, 1'b1, 1'b1, 32'h10, 4'h2, 32'hFFFF_FFFF);
      chk_en = 1'b1;
      step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("reset_rdata", bus.rdata_o, 32'h0);
      chk("reset_sram_en", 32'({bus.sram_re_o, bus.sram_we_o, bus.stall_o, bus.misalign_o}), 32'h0);
      nop();

      // word store then signed/unsigned byte loads from lane 3
      step(1'b0, 1'b1, 1'b0, 32'h10, 4'b0010, 32'hDEAD_BEEF);
      step(1'b0, 1'b0, 1'b1, 32'h13, 4'b0000, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h13, 4'b0100, 32'h0);
      @(negedge clk) chk("ld_byte_signed", bus.rdata_o, 32'hFFFF_FFDE);
      nop();
      @(negedge clk) chk("ld_byte_unsigned", bus.rdata_o, 32'h0000_00DE);

      // half store over existing word: one stall cycle, then merged readback
      step(1'b0, 1'b1, 1'b0, 32'h12, 4'b0001, 32'h0000_1234);
      nop();
      @(negedge clk) chk("half_st_stall", 32'(bus.stall_o), 32'h1);
      nop();
      @(negedge clk) chk("half_st_unstall", 32'(bus.stall_o), 32'h0);
      chk("half_st_sram", sram[4], 32'h1234_BEEF);
      step(1'b0, 1'b0, 1'b1, 32'h10, 4'b0010, 32'h0);
      nop();
      @(negedge clk) chk("half_st_readback", bus.rdata_o, 32'h1234_BEEF);

      // misaligned half load
      step(1'b0, 1'b0, 1'b1, 32'h11, 4'b0001, 32'h0);
      #1 chk("mis_no_sram", 32'({bus.sram_re_o, bus.sram_we_o}), 32'h0);
      nop();
      @(negedge clk) chk("mis_flag", 32'(bus.misalign_o), 32'h1);
      chk("mis_rdata", bus.rdata_o, 32'h0);
      chk("mis_word_kept", sram[4], 32'h1234_BEEF);

      // byte store followed by a load held through the stall
      step(1'b0, 1'b1, 1'b0, 32'h20, 4'b0010, 32'h1122_3344);
      step(1'b0, 1'b1, 1'b0, 32'h20, 4'b0000, 32'hFFFF_FFAA);
      step(1'b0, 1'b0, 1'b1, 32'h20, 4'b0010, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h20, 4'b0010, 32'h0);
      nop();
      @(negedge clk) chk("byte_st_then_ld", bus.rdata_o, 32'h1122_33AA);

      // reset during MERGE drops the pending write
      step(1'b0, 1'b1, 1'b0, 32'h40, 4'b0010, 32'h5566_7788);
      step(1'b0, 1'b1, 1'b0, 32'h41, 4'b0000, 32'h0000_0099);
      step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      #1 chk("rst_merge_no_we", 32'({bus.sram_we_o, bus.stall_o}), 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      nop();
      @(negedge clk) chk("rst_merge_word", sram[16], 32'h5566_7788);

`ifdef DATA_MEM_BRIDGE_MMIO_EN
      saved = sram[0];
      step(1'b0, 1'b1, 1'b0, 32'h2000, 4'b0010, 32'h5A5A_0001);
      nop();
      @(negedge clk) chk("mmio_reg", bus.mmio_o, 32'h5A5A_0001);
      chk("mmio_sram_kept", sram[0], saved);
      step(1'b0, 1'b0, 1'b1, 32'h2000, 4'b0010, 32'h0);
      nop();
      @(negedge clk) chk("mmio_load", bus.rdata_o, 32'h5A5A_0001);
`else
      saved = 32'h0;
`endif

      for (int n = 0; n < 3000; n++) begin
         int unsigned r;
         logic [31:0] a;
         r = $urandom_range(99);
         a = ($urandom & 32'hFFFF_F000) | ($urandom_range(15) << 2) | $urandom_range(3);
         if ($urandom_range(15) == 0) a = 32'h0000_2000 | $urandom_range(3);
         step(($urandom_range(199) == 0), (r < 30 || r >= 95), ((r >= 30 && r < 70) || r >= 95),
              a, 4'($urandom), $urandom);
      end
      nop();
      nop();
      nop();

      mism = 0;
      for (int i = 0; i < (1 << AW); i++) if (sram[i] !== model_mem[i]) mism++;
      chk("sram_image_mismatches", 32'(mism), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Sits between the RV32I core's execute-stage data-memory port and a single-port synchronous word SRAM with no byte enables. Handles byte lanes and sign/zero extension for loads. Implements sub-word stores as a two-cycle read-modify-write. Flags misaligned accesses and, optionally, maps one 32-bit output register into the address space.

## Interface
Parameters:
- ADDR_W, 10, SRAM word-address width (depth 2^ADDR_W words)
- MMIO_BASE, 32'h0000_2000, byte address of the MMIO register (used only with the MMIO macro)

Ports:
- clk_i  in  1  single clock, all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- req_addr_i  in  32  byte address from EX stage
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_we_i  in  1  store request
- req_re_i  in  1  load request
- req_mask_i  in  4  [1:0] size (00 byte, 01 half, 10 word, 11 reserved, treated as word); [2] unsigned load; [3] ignored
- rdata_o  out  32  aligned, extended load data, valid in MA (cycle after request)
- stall_o  out  1  core must hold EX and re-present its request next cycle
- misalign_o  out  1  misaligned access flag, aligned to MA
- sram_addr_o  out  ADDR_W  word address = req_addr_i[ADDR_W+1:2]
- sram_re_o  out  1  SRAM read enable
- sram_we_o  out  1  SRAM write enable (full word)
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data, one cycle after sram_re_o
- mmio_o  out  32  MMIO register contents

## Operation
- FSM states: IDLE, MERGE.
- IDLE, requests:
  - Load: sram_re_o=1. Latch offset addr[1:0], size and unsigned bit into load-info flops.
  - Aligned word store: sram_we_o=1, sram_wdata_o=req_wdata_i. Stays in IDLE.
  - Byte or half store: sram_re_o=1. Latch word address, data, size and offset. Go to MERGE.
  - No request: SRAM enables 0.
- MERGE:
  - stall_o=1 for the whole cycle. Any core request presented in this cycle is ignored.
  - Replace the addressed lanes of sram_rdata_i with store data. Issue sram_we_o=1 with the merged word to the latched address.
  - Return to IDLE.
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Sign-extend unless unsigned=1; word loads pass through.
- rdata_o=0 in any cycle not following an accepted load.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - No SRAM access and no state change.
  - misalign_o=1 for exactly the following cycle; rdata_o=0 that cycle.
- req_we_i and req_re_i both high: store wins, load ignored.
- Address bits above ADDR_W+1 are ignored; accesses wrap modulo 2^ADDR_W words.

## Timing
- Load latency 1: request in cycle N, rdata_o valid in cycle N+1.
- Word store: SRAM written at the end of cycle N; no stall.
- Sub-word store:
  - Cycle N: read issued.
  - Cycle N+1: MERGE, write issued, stall_o=1.
  - Cycle N+2: next request accepted.
  - A load to the same word re-presented in N+2 returns the merged data in N+3.
- stall_o is combinational from state only (never from request inputs).
- Reset values: state IDLE, rdata_o=0, stall_o=0, misalign_o=0, sram_re_o=0, sram_we_o=0, mmio_o=0, load-info cleared.
- Reset asserted during MERGE: pending write dropped, SRAM not written, IDLE on release.

## Configuration
- DATA_MEM_BRIDGE_MMIO_EN defined:
  - Word-aligned accesses with req_addr_i==MMIO_BASE go to the mmio register, never to the SRAM.
  - Word store writes the register in cycle N; visible on mmio_o from N+1.
  - Any load returns the register in N+1.
  - Sub-word stores to MMIO_BASE are treated as misaligned.
- Not defined: mmio_o tied to 0; MMIO_BASE is an ordinary SRAM address.

## Structure
- Package data_mem_bridge_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state enum
  - default MMIO_BASE
- One combinational sub-module, lane_align, performs load lane extraction plus extension and store lane merge. Instantiated once for each use.
- FSM, latches and MMIO register live in the top module.

## Test plan
- Store word 0xDEADBEEF to addr 0x10, then load byte signed from 0x13 -> rdata_o=0xFFFFFFDE one cycle after the load request; load byte unsigned from 0x13 -> 0x000000DE.
- Store half 0x1234 to 0x12 over 0xDEADBEEF -> stall_o high for exactly one cycle, SRAM word 4 = 0x1234BEEF; load word re-presented after the stall -> 0x1234BEEF.
- Load half from 0x11 -> no SRAM enable, misalign_o=1 next cycle, rdata_o=0, word unchanged.
- Store byte 0xAA to 0x20, then immediately load word from 0x20 (held through stall) -> rdata_o shows 0xAA in [7:0] with the other bytes preserved.
- Assert reset_i during MERGE of a byte store -> sram_we_o never asserted, all outputs 0, SRAM word unchanged.
- With DATA_MEM_BRIDGE_MMIO_EN: store 0x5A5A0001 to 0x2000 -> mmio_o=0x5A5A0001 next cycle, SRAM word (0x2000>>2) mod 2^ADDR_W unchanged, load 0x2000 returns 0x5A5A0001.
